dp_stream_tx: RTL and testbench
===============================

# dp_stream_tx

Video stream source that produces the 27-bit display-port word (hsync, vsync, de, R, G, B) consumed by the pixel processing pipeline. It generates raster timing from parameterised porch/sync widths, fetches active pixels from a 2048x24 line memory with 1-cycle read latency, and drives a registered output word. It sits at the head of the display path and replaces the bench-driven DPi stimulus.

## Interface
- H_ACT, 1920, active pixels per line (≤2048)
- H_FP / H_SYNC / H_BP, 88 / 44 / 148, horizontal front porch / sync / back porch in clocks
- V_ACT, 1080, active lines per frame
- V_FP / V_SYNC / V_BP, 4 / 5 / 36, vertical front porch / sync / back porch in lines
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  level; request streaming
- pat_en  in  1  select internal colour bars (used only with DPTX_COLORBAR_EN)
- mem_rdata  in  24  line-memory read data {R,G,B}, valid 1 clk after mem_ren
- mem_ren  out  1  line-memory read enable
- mem_addr  out  11  line-memory address (= pixel column)
- DPo  out  27  {hsync, vsync, de, R[7:0], G[7:0], B[7:0]}
- frame_start  out  1  1-clk pulse when pixel (0,0) appears on DPo
- busy  out  1  high from leaving IDLE until the pipeline is empty
- frame_cnt  out  16  completed frames, wraps at 65535→0

## Operation
- H_TOT = H_ACT+H_FP+H_SYNC+H_BP; V_TOT likewise. Counters h_cnt, v_cnt are 12 bits; h wraps at H_TOT-1 and increments v; v wraps at V_TOT-1.
- Regions (counter stage): de = h<H_ACT && v<V_ACT; hsync = H_ACT+H_FP ≤ h < H_ACT+H_FP+H_SYNC; vsync = V_ACT+V_FP ≤ v < V_ACT+V_FP+V_SYNC, for the whole line. Both syncs are active-high.
- State machine:
  - IDLE: counters held at 0. en=1 → RUN.
  - RUN: counters advance every clk. en=0 → DRAIN.
  - DRAIN: counters advance. At (H_TOT-1, V_TOT-1) → FLUSH. en re-asserted in DRAIN → RUN with no gap.
  - FLUSH: 2 clks with pipeline-valid cleared, then IDLE.
- Frames always start at (0,0) and only complete frames are emitted.
- Memory fetch: mem_ren = de (counter stage) in RUN/DRAIN; mem_addr = h_cnt[10:0] combinationally from the counter register. The line memory is refilled externally during blanking; this block does not track line number.
- Output register: R,G,B = mem_rdata when the delayed de=1, else 0. Sync and de are delayed 2 stages to align with data.
- DPo = 0 whenever the output stage holds no valid RUN/DRAIN position (IDLE, FLUSH tail).
- frame_cnt increments on the clk the last position (H_TOT-1, V_TOT-1) leaves the output stage.
- Reset mid-frame: all state clears immediately; no partial-frame completion.

## Timing
- Reset values: DPo=0, mem_ren=0, mem_addr=0, frame_start=0, busy=0, frame_cnt=0; state IDLE.
- en sampled high at edge N → RUN at N; counter (0,0) valid N+1; mem_ren=1 during cycle N+1; DPo shows pixel (0,0) after edge N+3, with frame_start=1 in that same cycle.
- Latency counter→DPo: 2 clk for all 27 bits; there are no per-field skews.
- Throughput: 1 pixel/clk; frame period exactly H_TOT*V_TOT clk in back-to-back frames.
- busy rises with the RUN transition and falls when FLUSH exits.

## Configuration
- DPTX_COLORBAR_EN defined: when pat_en=1, active RGB = 8 vertical bars, each H_ACT/8 wide (integer division; the remainder is black). Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. mem_ren is forced 0 when pat_en=1. pat_en is sampled per pixel and aligned to the data stage.
- Not defined: pat_en is ignored; RGB always comes from memory.

## Test plan
Small parameters: H_ACT=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOT=14); V_ACT=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOT=7).
- Reset check: hold rst_n=0 with en=1 → DPo=0, busy=0, frame_cnt=0; release → first de at DPo 3 clk after the first en-high edge.
- Timing: memory returns addr*0x010101; run 1 frame → 32 de cycles per frame; per line RGB 000000..070707; hsync high 2 clk starting 10 clk after line start; vsync high for line 5 only; frame period 98 clk.
- Stop: drop en mid-frame (v=2) → frame completes, frame_cnt=1, busy falls 2 clk after last position, DPo=0 afterwards.
- Re-arm: drop en then re-raise it during DRAIN → next frame starts back-to-back; frame_start pulses exactly 98 clk apart.
- Async reset mid-line (h=5, v=1) → all outputs 0 immediately; the next en restarts at (0,0).
- DPTX_COLORBAR_EN, pat_en=1 → line RGB = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; mem_ren stays 0.

Source files
------------

// File: rtl/dp_stream_tx_if.sv
// Stream-source bundle for dp_stream_tx: streaming request, line-memory port and
// the 27-bit display word with its status outputs.
interface dp_stream_tx_if;
    logic        en;
    logic        pat_en;
    logic [23:0] mem_rdata;
    logic        mem_ren;
    logic [10:0] mem_addr;
    logic [26:0] DPo;
    logic        frame_start;
    logic        busy;
    logic [15:0] frame_cnt;

    modport master (
        input  en, pat_en, mem_rdata,
        output mem_ren, mem_addr, DPo, frame_start, busy, frame_cnt
    );

    modport slave (
        output en, pat_en, mem_rdata,
        input  mem_ren, mem_addr, DPo, frame_start, busy, frame_cnt
    );
endinterface

// File: rtl/dp_stream_tx.sv
// Raster-timed video source: counter stage -> align stage (memory read) -> output word.
// Optional feature macro: DPTX_COLORBAR_EN (internal 8-bar test pattern selected by pat_en).
module dp_stream_tx #(
    parameter int unsigned H_ACT  = 1920,
    parameter int unsigned H_FP   = 88,
    parameter int unsigned H_SYNC = 44,
    parameter int unsigned H_BP   = 148,
    parameter int unsigned V_ACT  = 1080,
    parameter int unsigned V_FP   = 4,
    parameter int unsigned V_SYNC = 5,
    parameter int unsigned V_BP   = 36
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dp_stream_tx_if.master        dp_io
);

    localparam logic [11:0] H_LAST  = 12'(H_ACT + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_LAST  = 12'(V_ACT + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] H_ACT_L = 12'(H_ACT);
    localparam logic [11:0] V_ACT_L = 12'(V_ACT);
    localparam logic [11:0] HS_BEG  = 12'(H_ACT + H_FP);
    localparam logic [11:0] HS_END  = 12'(H_ACT + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG  = 12'(V_ACT + V_FP);
    localparam logic [11:0] VS_END  = 12'(V_ACT + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FLUSH
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;
    logic        vld_q, vld_d;
    logic        flush_q, flush_d;
    logic        step;

    // Align stage (same cycle as the memory access)
    logic        vld1_q, de1_q, hs1_q, vs1_q, first1_q, last1_q;
    // Output stage
    logic [26:0] dpo_q, dpo_d;
    logic        fs_q, fs_d;
    logic        vld2_q, last2_q;
    logic [15:0] fcnt_q, fcnt_d;

    logic        cnt_de, cnt_hs, cnt_vs, cnt_last, cnt_first;
    logic [23:0] rgb_sel;
    logic        ren;

    assign cnt_de    = vld_q && (h_q < H_ACT_L) && (v_q < V_ACT_L);
    assign cnt_hs    = vld_q && (h_q >= HS_BEG) && (h_q < HS_END);
    assign cnt_vs    = vld_q && (v_q >= VS_BEG) && (v_q < VS_END);
    assign cnt_last  = vld_q && (h_q == H_LAST) && (v_q == V_LAST);
    assign cnt_first = vld_q && (h_q == '0) && (v_q == '0);

    // The first RUN cycle only arms the counter stage, so (0,0) becomes valid one clk later.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        vld_d   = vld_q;
        flush_d = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (dp_io.en) state_d = S_RUN;
            end
            S_RUN: begin
                step = 1'b1;
                if (!dp_io.en) state_d = cnt_last ? S_FLUSH : S_DRAIN;
            end
            S_DRAIN: begin
                step = 1'b1;
                if (dp_io.en)    state_d = S_RUN;
                else if (cnt_last) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                flush_d = !flush_q;
                if (flush_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (step) begin
            if (!vld_q) begin
                vld_d = 1'b1;
            end else if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 12'd1;
            end else begin
                h_d = h_q + 12'd1;
            end
        end

        if (state_d == S_FLUSH || state_d == S_IDLE) begin
            vld_d = 1'b0;
            h_d   = '0;
            v_d   = '0;
        end
    end

`ifdef DPTX_COLORBAR_EN
    localparam int unsigned BAR_W = H_ACT / 8;

    logic [3:0]  bar_idx;
    logic [23:0] bar_rgb;
    logic        pat1_q;
    logic [23:0] bar1_q;

    // Bar index = number of bar boundaries already passed; past bar 7 is the black remainder.
    always_comb begin
        bar_idx = '0;
        for (int unsigned k = 1; k <= 8; k++) begin
            if ({20'd0, h_q} >= k * BAR_W) bar_idx = bar_idx + 4'd1;
        end
        unique case (bar_idx)
            4'd0:    bar_rgb = 24'hFFFFFF;
            4'd1:    bar_rgb = 24'hFFFF00;
            4'd2:    bar_rgb = 24'h00FFFF;
            4'd3:    bar_rgb = 24'h00FF00;
            4'd4:    bar_rgb = 24'hFF00FF;
            4'd5:    bar_rgb = 24'hFF0000;
            4'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat1_q <= 1'b0;
            bar1_q <= '0;
        end else begin
            pat1_q <= dp_io.pat_en;
            bar1_q <= bar_rgb;
        end
    end

    assign ren     = cnt_de && !dp_io.pat_en;
    assign rgb_sel = !de1_q ? '0 : (pat1_q ? bar1_q : dp_io.mem_rdata);
`else
    logic unused_pat_en;
    assign unused_pat_en = dp_io.pat_en;

    assign ren     = cnt_de;
    assign rgb_sel = de1_q ? dp_io.mem_rdata : '0;
`endif

    always_comb begin
        dpo_d  = vld1_q ? {hs1_q, vs1_q, de1_q, rgb_sel} : '0;
        fs_d   = vld1_q && first1_q;
        fcnt_d = (vld2_q && last2_q) ? fcnt_q + 16'd1 : fcnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            h_q      <= '0;
            v_q      <= '0;
            vld_q    <= 1'b0;
            flush_q  <= 1'b0;
            vld1_q   <= 1'b0;
            de1_q    <= 1'b0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            dpo_q    <= '0;
            fs_q     <= 1'b0;
            vld2_q   <= 1'b0;
            last2_q  <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            vld_q    <= vld_d;
            flush_q  <= flush_d;
            vld1_q   <= vld_q;
            de1_q    <= cnt_de;
            hs1_q    <= cnt_hs;
            vs1_q    <= cnt_vs;
            first1_q <= cnt_first;
            last1_q  <= cnt_last;
            dpo_q    <= dpo_d;
            fs_q     <= fs_d;
            vld2_q   <= vld1_q;
            last2_q  <= vld1_q && last1_q;
            fcnt_q   <= fcnt_d;
        end
    end

    assign dp_io.mem_ren     = ren;
    assign dp_io.mem_addr    = h_q[10:0];
    assign dp_io.DPo         = dpo_q;
    assign dp_io.frame_start = fs_q;
    assign dp_io.busy        = (state_q != S_IDLE);
    assign dp_io.frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_dp_stream_tx.sv
// Directed bench for dp_stream_tx with a 14x7 raster; memory returns addr*0x010101.
// Pattern checks follow DPTX_COLORBAR_EN when defined, otherwise pat_en must be ignored.
module tb_dp_stream_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dp_stream_tx_if dp_if ();

    dp_stream_tx #(
        .H_ACT (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACT (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dp_io (dp_if)
    );

    // Line memory model: 1-clk read latency
    always @(posedge clk) begin
        if (dp_if.mem_ren) dp_if.mem_rdata <= {3{dp_if.mem_addr[7:0]}};
    end

    function automatic logic [26:0] exp_dpo(input int h, input int v);
        logic       de, hs, vs;
        logic [7:0] c;
        de = (h < 8) && (v < 4);
        hs = (h >= 10) && (h < 12);
        vs = (v == 5);
        c  = de ? 8'(h) : 8'd0;
        return {hs, vs, de, c, c, c};
    endfunction

    function automatic logic exp_de(input int p);
        return ((p % 14) < 8) && ((p / 14) < 4);
    endfunction

    task automatic test_reset();
        dp_if.en     = 1'b1;
        dp_if.pat_en = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dp_if.DPo !== 27'd0) begin errors++; $display("FAIL reset_dpo got %h exp 0", dp_if.DPo); end
        checks++; if (dp_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", dp_if.busy); end
        checks++; if (dp_if.frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_fcnt got %0d exp 0", dp_if.frame_cnt); end
        checks++; if (dp_if.mem_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b exp 0", dp_if.mem_ren); end
        checks++; if (dp_if.mem_addr !== 11'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", dp_if.mem_addr); end
        checks++; if (dp_if.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", dp_if.frame_start); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (dp_if.busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b exp 1", dp_if.busy); end
        checks++; if (dp_if.mem_ren !== 1'b0) begin errors++; $display("FAIL start_ren_n got %b exp 0", dp_if.mem_ren); end
        @(negedge clk);
        checks++; if (dp_if.mem_ren !== 1'b1) begin errors++; $display("FAIL start_ren_n1 got %b exp 1", dp_if.mem_ren); end
        checks++; if (dp_if.DPo !== 27'd0) begin errors++; $display("FAIL start_dpo_n1 got %h exp 0", dp_if.DPo); end
        @(negedge clk);
        checks++; if (dp_if.mem_addr !== 11'd1) begin errors++; $display("FAIL start_addr_n2 got %0d exp 1", dp_if.mem_addr); end
        checks++; if (dp_if.DPo !== 27'd0) begin errors++; $display("FAIL start_dpo_n2 got %h exp 0", dp_if.DPo); end
        @(negedge clk);
        checks++; if (dp_if.DPo !== 27'h1000000) begin errors++; $display("FAIL start_dpo_n3 got %h exp 1000000", dp_if.DPo); end
        checks++; if (dp_if.frame_start !== 1'b1) begin errors++; $display("FAIL start_fs_n3 got %b exp 1", dp_if.frame_start); end
    endtask

    // Entered with pixel (0,0) of frame 1 on DPo
    task automatic test_timing();
        int de_cnt = 0;
        for (int p = 0; p < 98; p++) begin
            if (p > 0) @(negedge clk);
            checks++;
            if (dp_if.DPo !== exp_dpo(p % 14, p / 14)) begin
                errors++; $display("FAIL timing_dpo p=%0d got %h exp %h", p, dp_if.DPo, exp_dpo(p % 14, p / 14));
            end
            checks++;
            if (dp_if.frame_start !== (p == 0)) begin
                errors++; $display("FAIL timing_fs p=%0d got %b", p, dp_if.frame_start);
            end
            checks++;
            if (dp_if.mem_ren !== exp_de((p + 2) % 98)) begin
                errors++; $display("FAIL timing_ren p=%0d got %b exp %b", p, dp_if.mem_ren, exp_de((p + 2) % 98));
            end
            if (dp_if.DPo[24] === 1'b1) de_cnt++;
        end
        checks++; if (dp_if.frame_cnt !== 16'd0) begin errors++; $display("FAIL timing_fcnt_last got %0d exp 0", dp_if.frame_cnt); end
        checks++; if (de_cnt != 32) begin errors++; $display("FAIL timing_de_count got %0d exp 32", de_cnt); end
        @(negedge clk);
        checks++; if (dp_if.frame_start !== 1'b1) begin errors++; $display("FAIL timing_period_fs got %b exp 1", dp_if.frame_start); end
        checks++; if (dp_if.DPo !== 27'h1000000) begin errors++; $display("FAIL timing_period_dpo got %h exp 1000000", dp_if.DPo); end
        checks++; if (dp_if.frame_cnt !== 16'd1) begin errors++; $display("FAIL timing_fcnt got %0d exp 1", dp_if.frame_cnt); end
    endtask

    // Entered with pixel (0,0) of frame 2 on DPo; en drops on line 2
    task automatic test_stop();
        for (int p = 0; p < 98; p++) begin
            if (p > 0) @(negedge clk);
            checks++;
            if (dp_if.DPo !== exp_dpo(p % 14, p / 14)) begin
                errors++; $display("FAIL stop_dpo p=%0d got %h exp %h", p, dp_if.DPo, exp_dpo(p % 14, p / 14));
            end
            if (p == 31) dp_if.en = 1'b0;
        end
        checks++; if (dp_if.busy !== 1'b1) begin errors++; $display("FAIL stop_busy_last got %b exp 1", dp_if.busy); end
        checks++; if (dp_if.frame_cnt !== 16'd1) begin errors++; $display("FAIL stop_fcnt_last got %0d exp 1", dp_if.frame_cnt); end
        @(negedge clk);
        checks++; if (dp_if.busy !== 1'b0) begin errors++; $display("FAIL stop_busy_fall got %b exp 0", dp_if.busy); end
        checks++; if (dp_if.frame_cnt !== 16'd2) begin errors++; $display("FAIL stop_fcnt got %0d exp 2", dp_if.frame_cnt); end
        checks++; if (dp_if.DPo !== 27'd0) begin errors++; $display("FAIL stop_dpo_after got %h exp 0", dp_if.DPo); end
        repeat (3) @(negedge clk);
        checks++; if (dp_if.DPo !== 27'd0) begin errors++; $display("FAIL stop_dpo_idle got %h exp 0", dp_if.DPo); end
        checks++; if (dp_if.mem_ren !== 1'b0) begin errors++; $display("FAIL stop_ren_idle got %b exp 0", dp_if.mem_ren); end
        checks++; if (dp_if.frame_cnt !== 16'd2) begin errors++; $display("FAIL stop_fcnt_idle got %0d exp 2", dp_if.frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int found = 0;
        int t0;
        dp_if.en = 1'b1;
        while (found == 0 && n < 10) begin
            @(negedge clk); n++;
            if (dp_if.frame_start === 1'b1) found = 1;
        end
        checks++; if (found == 0 || n != 4) begin errors++; $display("FAIL rearm_latency got %0d exp 4 (found=%0d)", n, found); end
        t0 = cyc;
        for (int p = 1; p < 98; p++) begin
            @(negedge clk);
            if (p == 20) dp_if.en = 1'b0;
            if (p == 50) dp_if.en = 1'b1;
            if (p == 60) begin
                checks++; if (dp_if.busy !== 1'b1) begin errors++; $display("FAIL rearm_busy got %b exp 1", dp_if.busy); end
            end
        end
        n = 0; found = 0;
        while (found == 0 && n < 10) begin
            @(negedge clk); n++;
            if (dp_if.frame_start === 1'b1) found = 1;
        end
        checks++; if (found == 0 || (cyc - t0) != 98) begin errors++; $display("FAIL rearm_period got %0d exp 98 (found=%0d)", cyc - t0, found); end
        checks++; if (dp_if.DPo !== 27'h1000000) begin errors++; $display("FAIL rearm_dpo got %h exp 1000000", dp_if.DPo); end
        checks++; if (dp_if.frame_cnt !== 16'd3) begin errors++; $display("FAIL rearm_fcnt got %0d exp 3", dp_if.frame_cnt); end
    endtask

    // Entered with (0,0) on DPo; counter runs 2 positions ahead of the output
    task automatic test_async_reset();
        int n = 0;
        int found = 0;
        repeat (17) @(negedge clk);
        checks++; if (dp_if.mem_addr !== 11'd5) begin errors++; $display("FAIL arst_pos_addr got %0d exp 5", dp_if.mem_addr); end
        checks++; if (dp_if.DPo !== exp_dpo(3, 1)) begin errors++; $display("FAIL arst_pos_dpo got %h exp %h", dp_if.DPo, exp_dpo(3, 1)); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dp_if.DPo !== 27'd0) begin errors++; $display("FAIL arst_dpo got %h exp 0", dp_if.DPo); end
        checks++; if (dp_if.busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", dp_if.busy); end
        checks++; if (dp_if.frame_cnt !== 16'd0) begin errors++; $display("FAIL arst_fcnt got %0d exp 0", dp_if.frame_cnt); end
        checks++; if (dp_if.mem_ren !== 1'b0) begin errors++; $display("FAIL arst_ren got %b exp 0", dp_if.mem_ren); end
        checks++; if (dp_if.mem_addr !== 11'd0) begin errors++; $display("FAIL arst_addr got %0d exp 0", dp_if.mem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        while (found == 0 && n < 10) begin
            @(negedge clk); n++;
            if (dp_if.frame_start === 1'b1) found = 1;
        end
        checks++; if (found == 0 || n != 4) begin errors++; $display("FAIL arst_restart got %0d exp 4 (found=%0d)", n, found); end
        checks++; if (dp_if.DPo !== 27'h1000000) begin errors++; $display("FAIL arst_restart_dpo got %h exp 1000000", dp_if.DPo); end
        @(negedge clk);
        checks++; if (dp_if.DPo !== exp_dpo(1, 0)) begin errors++; $display("FAIL arst_next_dpo got %h exp %h", dp_if.DPo, exp_dpo(1, 0)); end
    endtask

    task automatic test_pattern();
        logic [23:0] bars [8];
        logic [23:0] exp_rgb;
        logic        exp_ren;
        int          n = 0;
        int          found = 0;
        int          ren_seen = 0;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        dp_if.pat_en = 1'b1;
        while (found == 0 && n < 110) begin
            @(negedge clk); n++;
            if (dp_if.mem_ren === 1'b1) ren_seen++;
            if (dp_if.frame_start === 1'b1) found = 1;
        end
        checks++; if (found == 0) begin errors++; $display("FAIL pat_frame_start got none exp pulse"); end
        for (int h = 0; h < 8; h++) begin
            if (h > 0) @(negedge clk);
`ifdef DPTX_COLORBAR_EN
            exp_rgb = bars[h];
            exp_ren = 1'b0;
`else
            exp_rgb = {3{8'(h)}};
            exp_ren = (h + 2) < 8;
`endif
            checks++;
            if (dp_if.DPo !== {3'b001, exp_rgb}) begin
                errors++; $display("FAIL pat_rgb h=%0d got %h exp %h", h, dp_if.DPo, {3'b001, exp_rgb});
            end
            checks++;
            if (dp_if.mem_ren !== exp_ren) begin
                errors++; $display("FAIL pat_ren h=%0d got %b exp %b", h, dp_if.mem_ren, exp_ren);
            end
        end
`ifdef DPTX_COLORBAR_EN
        checks++; if (ren_seen != 0) begin errors++; $display("FAIL pat_ren_quiet got %0d exp 0", ren_seen); end
`else
        checks++; if (ren_seen == 0) begin errors++; $display("FAIL pat_ren_active got %0d exp >0", ren_seen); end
`endif
        dp_if.pat_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timing();
        test_stop();
        test_back_to_back();
        test_async_reset();
        test_pattern();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
